// File: rtl/apb_pkg.sv
// Shared types for the two-requester APB master.
// Bus widths, FSM state encoding, command and response bundles.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
  } apb_rsp_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with last-grant memory.
// Ports: PCLK, PRESET, req[1:0], advance, gnt[1:0] (one-hot or zero).
module rr_arbiter2 (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // 1 = requester 1 won last; reset value makes req0 win the first tie
  logic last_q;

  always_comb begin
    unique case (req)
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      last_q <= 1'b1;
    end else if (advance) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master shared by two requesters: round-robin accept, SETUP/ACCESS, PREADY timeout.
// Ports: PCLK/PRESET, req_* command side, rsp_* completion side, APB master signals.
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic [1:0]             req_valid,
  input  logic [1:0]             req_write,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][DATA_W-1:0] req_wdata,
  output logic [1:0]             req_ready,
  output logic [1:0]             rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic                   PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [ADDR_W-1:0]      PADDR,
  output logic [DATA_W-1:0]      PWDATA,
  input  logic [DATA_W-1:0]      PRDATA,
  input  logic                   PREADY,
  input  logic                   PSLVERR
);

  // Last ACCESS cycle allowed without PREADY
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  apb_state_e state_q, state_d;
  apb_cmd_t   cmd_q, cmd_d;
  apb_rsp_t   rsp_q, rsp_d;
  logic       psel_q, psel_d;
  logic       pen_q, pen_d;
  logic [1:0] rspv_q, rspv_d;
  logic       gsel_q, gsel_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] gnt;
  logic       accept;

  rr_arbiter2 u_arb (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .req     (req_valid),
    .advance (accept),
    .gnt     (gnt)
  );

  assign accept    = (state_q == IDLE) && (|req_valid);
  assign req_ready = accept ? gnt : 2'b00;

  assign PSEL      = psel_q;
  assign PENABLE   = pen_q;
  assign PWRITE    = cmd_q.write;
  assign PADDR     = cmd_q.addr;
  assign PWDATA    = cmd_q.wdata;
  assign rsp_valid = rspv_q;
  assign rsp_rdata = rsp_q.rdata;
  assign rsp_err   = rsp_q.err;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    rsp_d   = rsp_q;
    psel_d  = psel_q;
    pen_d   = pen_q;
    rspv_d  = 2'b00;
    gsel_d  = gsel_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cmd_d.write = req_write[gnt[1]];
          cmd_d.addr  = req_addr[gnt[1]];
          cmd_d.wdata = req_wdata[gnt[1]];
          gsel_d  = gnt[1];
          psel_d  = 1'b1;
          pen_d   = 1'b0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        pen_d   = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          rspv_d[gsel_q] = 1'b1;
          rsp_d.rdata = cmd_q.write ? '0 : PRDATA;
          rsp_d.err   = PSLVERR;
          psel_d  = 1'b0;
          pen_d   = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == TMO_LAST) begin
          // Hung slave: force an error completion
          rspv_d[gsel_q] = 1'b1;
          rsp_d.rdata = '0;
          rsp_d.err   = 1'b1;
          psel_d  = 1'b0;
          pen_d   = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      rsp_q   <= '0;
      psel_q  <= 1'b0;
      pen_q   <= 1'b0;
      rspv_q  <= 2'b00;
      gsel_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      rsp_q   <= rsp_d;
      psel_q  <= psel_d;
      pen_q   <= pen_d;
      rspv_q  <= rspv_d;
      gsel_q  <= gsel_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter with a small APB slave model.
// Covers reset, read/write, slave errors, contention, timeout, wait states.
module tb_apb_master_arbiter;

  logic             PCLK = 1'b0;
  logic             PRESET;
  logic [1:0]       req_valid;
  logic [1:0]       req_write;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0]       req_ready;
  logic [1:0]       rsp_valid;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;
  logic             PSEL, PENABLE, PWRITE;
  logic [31:0]      PADDR, PWDATA, PRDATA;
  logic             PREADY, PSLVERR;

  int n_tests = 0;
  int n_fail  = 0;

  apb_master_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave model: 16 words at 0x00..0x3C; unwritten reads error with all-ones
  logic [31:0] mem [16];
  logic [15:0] vld;
  logic        hit;
  logic [3:0]  idx;
  int          wait_n = 0;
  bit          hang   = 0;
  int          acc_cnt;

  assign hit    = PADDR < 32'h40;
  assign idx    = PADDR[5:2];
  assign PREADY = PSEL && PENABLE && !hang && (acc_cnt >= wait_n);

  always_comb begin
    PRDATA  = 32'h0;
    PSLVERR = 1'b1;
    if (hit) begin
      PRDATA  = vld[idx] ? mem[idx] : 32'hFFFF_FFFF;
      PSLVERR = !PWRITE && !vld[idx];
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      vld     <= '0;
      acc_cnt <= 0;
    end else begin
      acc_cnt <= (PSEL && PENABLE && !PREADY) ? acc_cnt + 1 : 0;
      if (PSEL && PENABLE && PREADY && PWRITE && hit) begin
        mem[idx] <= PWDATA;
        vld[idx] <= 1'b1;
      end
    end
  end

  // Free-running monitors
  int          cyc       = 0;
  int          acc_total = 0;
  int          unstable  = 0;
  logic [64:0] snap;

  always_ff @(posedge PCLK) begin
    cyc <= cyc + 1;
    if (PSEL && !PENABLE) snap <= {PWRITE, PADDR, PWDATA};
    if (PSEL && PENABLE) begin
      acc_total <= acc_total + 1;
      if ({PWRITE, PADDR, PWDATA} != snap) unstable <= unstable + 1;
    end
  end

  always @(negedge PCLK) begin
    if (|rsp_valid) chk("rsp_onehot", 64'($onehot(rsp_valid)), 64'd1);
  end

  task automatic xfer(input int r, input bit w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output bit er, output int lat,
                      output logic [1:0] p1, output logic [1:0] p2);
    int t;
    rd = 'x; er = 1'bx; lat = 0; p1 = 'x; p2 = 'x;
    @(negedge PCLK);
    req_valid[r] = 1'b1;
    req_write[r] = w;
    req_addr[r]  = a;
    req_wdata[r] = d;
    #1;
    t = 0;
    while (!req_ready[r] && t < 50) begin
      @(negedge PCLK); #1; t++;
    end
    if (!req_ready[r]) begin
      chk("ready_bound", 64'd0, 64'd1);
      req_valid[r] = 1'b0;
      return;
    end
    @(posedge PCLK); #1;
    req_valid[r] = 1'b0;
    lat = 1;
    p1 = {PSEL, PENABLE};
    while (!rsp_valid[r] && lat < 50) begin
      @(posedge PCLK); #1; lat++;
      if (lat == 2) p2 = {PSEL, PENABLE};
    end
    if (!rsp_valid[r]) chk("rsp_bound", 64'd0, 64'd1);
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  logic [31:0] rd;
  bit          er;
  int          lat, base;
  logic [1:0]  p1, p2;
  int          order [4];
  int          acc   [4];
  int          n;

  initial begin
    #200000;
    $display("FAIL watchdog: got no-finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESET = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge PCLK);
    #1;
    chk("rst_psel", {63'd0, PSEL}, 64'd0);
    chk("rst_penable", {63'd0, PENABLE}, 64'd0);
    chk("rst_pwrite", {63'd0, PWRITE}, 64'd0);
    chk("rst_paddr", {32'd0, PADDR}, 64'd0);
    chk("rst_pwdata", {32'd0, PWDATA}, 64'd0);
    chk("rst_rsp", {29'd0, rsp_valid, rsp_err, rsp_rdata}, 64'd0);
    @(negedge PCLK);
    PRESET = 1'b0;

    // Write then read, req0 only
    xfer(0, 1'b1, 32'h4, 32'hDEAD_BEEF, rd, er, lat, p1, p2);
    chk("wr_setup", {62'd0, p1}, 64'h2);
    chk("wr_access", {62'd0, p2}, 64'h3);
    chk("wr_lat", 64'(lat), 64'd3);
    chk("wr_err", {63'd0, er}, 64'd0);
    xfer(0, 1'b0, 32'h4, 32'h0, rd, er, lat, p1, p2);
    chk("rd_lat", 64'(lat), 64'd3);
    chk("rd_data", {32'd0, rd}, 64'hDEAD_BEEF);
    chk("rd_err", {63'd0, er}, 64'd0);

    // Slave errors
    xfer(0, 1'b0, 32'h8, 32'h0, rd, er, lat, p1, p2);
    chk("unwr_data", {32'd0, rd}, 64'hFFFF_FFFF);
    chk("unwr_err", {63'd0, er}, 64'd1);
    xfer(0, 1'b0, 32'h40, 32'h0, rd, er, lat, p1, p2);
    chk("oor_data", {32'd0, rd}, 64'h0);
    chk("oor_err", {63'd0, er}, 64'd1);

    // Wait states
    wait_n = 2;
    base = acc_total;
    xfer(0, 1'b1, 32'hC, 32'hCAFE_0001, rd, er, lat, p1, p2);
    chk("ws_lat", 64'(lat), 64'd5);
    chk("ws_acc_cycles", 64'(acc_total - base), 64'd3);
    chk("ws_stable", 64'(unstable), 64'd0);
    chk("ws_err", {63'd0, er}, 64'd0);
    wait_n = 0;

    // Timeout
    hang = 1;
    base = acc_total;
    xfer(0, 1'b0, 32'h4, 32'h0, rd, er, lat, p1, p2);
    chk("tmo_acc_cycles", 64'(acc_total - base), 64'd4);
    chk("tmo_lat", 64'(lat), 64'd6);
    chk("tmo_data", {32'd0, rd}, 64'h0);
    chk("tmo_err", {63'd0, er}, 64'd1);
    hang = 0;
    xfer(0, 1'b0, 32'h4, 32'h0, rd, er, lat, p1, p2);
    chk("post_tmo_data", {32'd0, rd}, 64'hDEAD_BEEF);
    chk("post_tmo_lat", 64'(lat), 64'd3);

    // Reset during ACCESS
    hang = 1;
    @(negedge PCLK);
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h4;
    @(posedge PCLK); #1;
    req_valid[0] = 1'b0;
    @(posedge PCLK); #1;
    chk("mid_in_access", {62'd0, PSEL, PENABLE}, 64'h3);
    @(negedge PCLK);
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    chk("mid_rst_bus", {62'd0, PSEL, PENABLE}, 64'h0);
    chk("mid_rst_rsp", {62'd0, rsp_valid}, 64'h0);
    @(negedge PCLK);
    PRESET = 1'b0;
    hang = 0;
    repeat (3) begin
      @(posedge PCLK); #1;
      chk("mid_no_rsp", {62'd0, rsp_valid}, 64'h0);
    end

    // Contention after reset: tie goes to req0, then alternate
    @(negedge PCLK);
    req_valid = 2'b11;
    req_write = 2'b11;
    req_addr[0] = 32'h10; req_wdata[0] = 32'h1111_1111;
    req_addr[1] = 32'h14; req_wdata[1] = 32'h2222_2222;
    n = 0;
    for (int k = 0; k < 60 && n < 4; k++) begin
      #1;
      if (|req_ready) begin
        order[n] = int'(req_ready[1]);
        acc[n]   = cyc;
        n++;
      end
      if (n < 4) @(negedge PCLK);
    end
    @(posedge PCLK); #1;
    req_valid = 2'b00;
    chk("cont_count", 64'(n), 64'd4);
    chk("cont_g0", 64'(order[0]), 64'd0);
    chk("cont_g1", 64'(order[1]), 64'd1);
    chk("cont_g2", 64'(order[2]), 64'd0);
    chk("cont_g3", 64'(order[3]), 64'd1);
    chk("cont_gap1", 64'(acc[1] - acc[0]), 64'd3);
    chk("cont_gap2", 64'(acc[2] - acc[1]), 64'd3);
    chk("cont_gap3", 64'(acc[3] - acc[2]), 64'd3);
    repeat (4) @(posedge PCLK);
    xfer(1, 1'b0, 32'h14, 32'h0, rd, er, lat, p1, p2);
    chk("req1_rd_data", {32'd0, rd}, 64'h2222_2222);
    chk("req1_rd_lat", 64'(lat), 64'd3);
    xfer(0, 1'b0, 32'h10, 32'h0, rd, er, lat, p1, p2);
    chk("req0_rd_data", {32'd0, rd}, 64'h1111_1111);

    repeat (2) @(posedge PCLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Two-requester APB master that shares one APB slave port (32-bit address/data, PREADY, PSLVERR) between two internal requesters.
- Arbitrates round-robin, latches the winning command, then runs the APB SETUP → ACCESS sequence and waits for PREADY.
- Returns read data and error status to the granted requester.
- Adds a PREADY timeout so a hung slave cannot lock the bus.

Parameters:
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width.
- TIMEOUT, 16, max ACCESS cycles without PREADY before forced error completion; legal range 1..255.

Ports:
- PCLK  in  1  bus clock; all logic on rising edge.
- PRESET  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester command valid.
- req_write  in  2  per-requester 1=write, 0=read.
- req_addr  in  2×ADDR_W  per-requester address, packed [1:0].
- req_wdata  in  2×DATA_W  per-requester write data.
- req_ready  out  2  command accepted this cycle, one-hot or zero.
- rsp_valid  out  2  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data, shared; qualified by rsp_valid.
- rsp_err  out  1  error flag, shared; qualified by rsp_valid.
- PSEL, PENABLE, PWRITE  out  1  APB control.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data.
- PREADY, PSLVERR  in  1  APB handshake and error.

Behaviour:
- Reset (PRESET=1 at an edge) clears all of the following:
  - PSEL, PENABLE, PWRITE → 0; PADDR, PWDATA → 0.
  - rsp_valid → 0; rsp_rdata → 0; rsp_err → 0.
  - FSM → IDLE; wait counter → 0; last_grant → 1, so req0 wins the first tie.
- Reset mid-transfer abandons the transfer: PSEL and PENABLE are low the cycle after reset, and no rsp_valid is issued.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - req_ready is combinational: the arbiter's one-hot grant when any req_valid is set.
  - Grant rule: if both requesters are valid, grant the one that is not last_grant; if one is valid, grant it.
  - On the accepting edge: latch addr, wdata and write of the granted requester, update last_grant, go to SETUP.
- SETUP: registered outputs PSEL=1, PENABLE=0, and PADDR/PWRITE/PWDATA from the latch. Next state is always ACCESS.
- ACCESS: PSEL=1, PENABLE=1, address and control held stable.
  - PREADY=1 at an edge:
    - Complete; the next cycle drives rsp_valid[g]=1.
    - rsp_rdata = PRDATA when reading, 0 when writing.
    - rsp_err = PSLVERR.
    - PSEL and PENABLE drop to 0 and the FSM goes to IDLE.
  - PREADY=0 at an edge: increment the wait counter.
  - Counter reaches TIMEOUT: complete with rsp_err=1 and rsp_rdata=0, then go to IDLE.
- Latency:
  - Accept edge to PSEL high: 1 cycle.
  - Zero-wait transfer from accept to rsp_valid: 3 cycles.
  - Minimum spacing between consecutive accepts: 3 cycles, because every transfer returns through IDLE and there is no back-to-back SETUP.
- Responses have no backpressure; the requester must take rsp_valid in the cycle it is high.
- req_valid/req_ready handshake:
  - A requester holds valid, write, addr and wdata stable until ready is seen.
  - Deasserting valid before ready is legal; nothing is latched.
- A requester may raise req_valid while its own transfer is in flight. It is accepted no earlier than the IDLE cycle that follows rsp_valid.
- PSLVERR and PRDATA are sampled only in ACCESS when PREADY=1 and are ignored otherwise.

Decomposition:
- Package apb_pkg:
  - apb_state_e enum (IDLE/SETUP/ACCESS).
  - ADDR_W/DATA_W default constants.
  - apb_cmd_t struct {write, addr, wdata}.
  - apb_rsp_t struct {rdata, err}.
- Sub-module rr_arbiter2:
  - Inputs: req[1:0] and an advance strobe.
  - Outputs: one-hot gnt[1:0].
  - Holds the last_grant register and applies the reset rule above.

Test Plan:
- Write then read, req0 only: write addr 0x4, data 0xDEADBEEF, then read 0x4 → PSEL/PENABLE follow SETUP then ACCESS; each rsp_valid[0] arrives 3 cycles after accept; read response is rdata=0xDEADBEEF, err=0.
- Read of an unwritten location after slave reset: read 0x8 → rsp_err=1, rsp_rdata=0xFFFFFFFF. Read of out-of-range address 0x40 → rsp_err=1, rsp_rdata=0.
- Contention: both requesters hold valid for 4 transfers → grant order 0,1,0,1; rsp_valid never asserted on both bits at once; accepts spaced 3 cycles apart.
- Timeout: TIMEOUT=4 with the bench holding PREADY=0 → ACCESS lasts 4 cycles, then rsp_err=1 and rsp_rdata=0; the next request proceeds normally.
- Reset mid-ACCESS: PRESET pulsed 1 cycle during ACCESS with PREADY=0 → the following cycle shows PSEL=0, PENABLE=0, no rsp_valid; after reset, a tie is won by req0.
- Wait states: PREADY low for 2 ACCESS cycles → PADDR, PWRITE and PWDATA stay constant throughout; rsp_valid arrives 5 cycles after accept.
